// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller: align, strobe, extend, one transaction in flight.
// Optional DMEM_TIMEOUT_EN adds an acknowledge watchdog driven by p_timeout.
module dmem_access_ctrl #(
    parameter logic [31:0] p_addr_base = 32'h10000000,
    parameter logic [31:0] p_addr_mask = 32'hfffff000,
    parameter int unsigned p_timeout   = 16
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [1:0]  i_req_size,
    input  logic        i_req_unsigned,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err,
    output logic [31:2] o_mem_addr,
    output logic [3:0]  o_mem_be,
    output logic        o_mem_wr_en,
    output logic [31:0] o_mem_wr_data,
    output logic        o_mem_rd_en,
    input  logic [31:0] i_mem_rd_data,
    input  logic        i_mem_busy,
    input  logic        i_mem_ack
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t      state;
    state_t      state_nxt;
    logic        we_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic        accept;
    logic        fault;
    logic        strobe;
    logic        active;
    logic        acked;
    logic        timed_out;
    logic [31:0] lane;
    logic [31:0] load_ext;
    logic [3:0]  be;
    logic [31:0] wr_data;

    assign o_req_ready = (state == IDLE);
    assign accept      = i_req_valid & o_req_ready;
    assign active      = (state == ISSUE) | (state == WAIT);
    assign strobe      = (state == ISSUE) & ~i_mem_busy;
    assign acked       = (strobe | (state == WAIT)) & i_mem_ack;

    assign fault = (i_req_size == 2'd3)
                 | ((i_req_size == 2'd1) & i_req_addr[0])
                 | ((i_req_size == 2'd2) & (|i_req_addr[1:0]))
                 | ((i_req_addr & p_addr_mask) != p_addr_base);

`ifdef DMEM_TIMEOUT_EN
    logic [31:0] cnt;

    assign timed_out = active & ~acked & (cnt == p_timeout - 1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= '0;
        end else if (active) begin
            cnt <= cnt + 32'd1;
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = (p_timeout != 0);
    assign timed_out      = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (i_req_valid) state_nxt = fault ? RESP : ISSUE;
            ISSUE:   if (!i_mem_busy) state_nxt = i_mem_ack ? RESP : WAIT;
            WAIT:    if (i_mem_ack) state_nxt = RESP;
            RESP:    if (i_rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (timed_out) state_nxt = RESP;
    end

    // Shift the addressed lane down to bit 0 before extending.
    always_comb begin
        lane     = i_mem_rd_data >> {addr_q[1:0], 3'b000};
        load_ext = lane;
        case (size_q)
            2'd0:    load_ext = {{24{~uns_q & lane[7]}}, lane[7:0]};
            2'd1:    load_ext = {{16{~uns_q & lane[15]}}, lane[15:0]};
            default: load_ext = lane;
        endcase
    end

    always_comb begin
        be      = 4'b1111;
        wr_data = wdata_q;
        case (size_q)
            2'd0: begin
                be      = 4'b0001 << addr_q[1:0];
                wr_data = {4{wdata_q[7:0]}};
            end
            2'd1: begin
                be      = 4'b0011 << {addr_q[1], 1'b0};
                wr_data = {2{wdata_q[15:0]}};
            end
            default: begin
                be      = 4'b1111;
                wr_data = wdata_q;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            we_q    <= 1'b0;
            size_q  <= 2'd0;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (accept) begin
            we_q    <= i_req_we;
            size_q  <= i_req_size;
            uns_q   <= i_req_unsigned;
            addr_q  <= i_req_addr;
            wdata_q <= i_req_wdata;
            rdata_q <= '0;
            err_q   <= fault;
        end else if (acked && !we_q) begin
            rdata_q <= load_ext;
        end else if (timed_out) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
        end
    end

    assign o_rsp_valid   = (state == RESP);
    assign o_rsp_rdata   = o_rsp_valid ? rdata_q : '0;
    assign o_rsp_err     = o_rsp_valid & err_q;
    assign o_mem_wr_en   = strobe & we_q;
    assign o_mem_rd_en   = strobe & ~we_q;
    assign o_mem_addr    = active ? addr_q[31:2] : '0;
    assign o_mem_be      = active ? be : '0;
    assign o_mem_wr_data = active ? wr_data : '0;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Scoreboard bench for dmem_access_ctrl: aligned/faulting accesses, stalls, reset, timeout.
// Build with DMEM_TIMEOUT_EN to exercise the acknowledge watchdog.
module tb_dmem_access_ctrl;

    localparam int unsigned TO = 16;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:2] mem_addr;
    logic [3:0]  mem_be;
    logic        mem_wr_en;
    logic [31:0] mem_wr_data;
    logic        mem_rd_en;
    logic [31:0] mem_rd_data;
    logic        mem_busy;
    logic        mem_ack;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    dmem_access_ctrl #(
        .p_addr_base(32'h10000000),
        .p_addr_mask(32'hfffff000),
        .p_timeout  (TO)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_req_valid   (req_valid),
        .o_req_ready   (req_ready),
        .i_req_we      (req_we),
        .i_req_size    (req_size),
        .i_req_unsigned(req_unsigned),
        .i_req_addr    (req_addr),
        .i_req_wdata   (req_wdata),
        .o_rsp_valid   (rsp_valid),
        .i_rsp_ready   (rsp_ready),
        .o_rsp_rdata   (rsp_rdata),
        .o_rsp_err     (rsp_err),
        .o_mem_addr    (mem_addr),
        .o_mem_be      (mem_be),
        .o_mem_wr_en   (mem_wr_en),
        .o_mem_wr_data (mem_wr_data),
        .o_mem_rd_en   (mem_rd_en),
        .i_mem_rd_data (mem_rd_data),
        .i_mem_busy    (mem_busy),
        .i_mem_ack     (mem_ack)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic m_fault(input logic [1:0] sz, input logic [31:0] a);
        if (a[31:12] != 20'h10000) return 1'b1;
        case (sz)
            2'd0:    return 1'b0;
            2'd1:    return a[0];
            2'd2:    return a[1:0] != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] m_rdata(input logic [1:0] sz, input logic uns,
                                            input logic [31:0] a, input logic [31:0] m);
        logic [7:0]  b;
        logic [15:0] h;
        case (a[1:0])
            2'd0:    b = m[7:0];
            2'd1:    b = m[15:8];
            2'd2:    b = m[23:16];
            default: b = m[31:24];
        endcase
        h = a[1] ? m[31:16] : m[15:0];
        case (sz)
            2'd0:    return uns ? {24'h0, b} : {{24{b[7]}}, b};
            2'd1:    return uns ? {16'h0, h} : {{16{h[15]}}, h};
            default: return m;
        endcase
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
        case (sz)
            2'd0: case (a[1:0])
                2'd0:    return 4'b0001;
                2'd1:    return 4'b0010;
                2'd2:    return 4'b0100;
                default: return 4'b1000;
            endcase
            2'd1:    return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] m_wd(input logic [1:0] sz, input logic [31:0] w);
        case (sz)
            2'd0:    return {w[7:0], w[7:0], w[7:0], w[7:0]};
            2'd1:    return {w[15:0], w[15:0]};
            default: return w;
        endcase
    endfunction

    task automatic drive_req(input logic we, input logic [1:0] sz, input logic uns,
                             input logic [31:0] a, input logic [31:0] w);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = a;
        req_wdata    = w;
    endtask

    task automatic txn(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] w,
                       input logic [31:0] m, input int busy_n,
                       input int ack_dly, input int rdy_dly);
        exp_t e;
        exp_t g;
        logic f;
        f       = m_fault(sz, a);
        e.err   = f;
        e.rdata = (f || we) ? 32'h0 : m_rdata(sz, uns, a, m);
        sb.push_back(e);
        @(negedge clk);
        drive_req(we, sz, uns, a, w);
        mem_rd_data = m;
        #1 chk("req_ready", req_ready, 1);
        @(negedge clk);
        req_valid = 1'b0;
        if (!f) begin
            for (int i = 0; i < busy_n; i++) begin
                mem_busy = 1'b1;
                #1 chk("busy_nostrobe", {mem_wr_en, mem_rd_en}, 0);
                @(negedge clk);
            end
            mem_busy = 1'b0;
            mem_ack  = (ack_dly == 0);
            #1;
            chk("wr_en", mem_wr_en, we);
            chk("rd_en", mem_rd_en, !we);
            chk("mem_addr", mem_addr, a[31:2]);
            chk("mem_be", mem_be, m_be(sz, a));
            if (we) chk("wr_data", mem_wr_data, m_wd(sz, w));
            @(negedge clk);
            mem_ack = 1'b0;
            for (int i = 0; i < ack_dly; i++) begin
                mem_ack = (i == ack_dly - 1);
                #1;
                chk("wait_nostrobe", {mem_wr_en, mem_rd_en}, 0);
                chk("wait_novalid", rsp_valid, 0);
                @(negedge clk);
                mem_ack = 1'b0;
            end
        end
        if (sb.size() == 0) begin
            chk("sb_empty", 1, 0);
            g = '0;
        end else begin
            g = sb.pop_front();
        end
        for (int i = 0; i <= rdy_dly; i++) begin
            rsp_ready = (i == rdy_dly);
            #1;
            chk("resp_nostrobe", {mem_wr_en, mem_rd_en}, 0);
            chk("rsp_valid", rsp_valid, 1);
            chk("rsp_rdata", rsp_rdata, g.rdata);
            chk("rsp_err", rsp_err, g.err);
            @(negedge clk);
        end
        rsp_ready = 1'b0;
        #1;
        chk("back_idle", req_ready, 1);
        chk("rsp_drop", rsp_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=stuck exp=finish");
        $fatal(1, "timeout");
    end

    initial begin
        int  n;
        logic seen;
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        rsp_ready    = 1'b0;
        mem_rd_data  = '0;
        mem_busy     = 1'b0;
        mem_ack      = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready", req_ready, 1);
        chk("rst_valid", rsp_valid, 0);
        chk("rst_strobe", {mem_wr_en, mem_rd_en}, 0);
        chk("rst_be", mem_be, 0);
        rst_n = 1'b1;

        txn(0, 2'd0, 0, 32'h10000003, 0, 32'h80AA5511, 0, 0, 0);
        txn(0, 2'd0, 1, 32'h10000003, 0, 32'h80AA5511, 0, 0, 0);
        txn(0, 2'd1, 0, 32'h10000002, 0, 32'h80AA5511, 0, 1, 0);
        txn(0, 2'd1, 1, 32'h10000000, 0, 32'h1234F00D, 0, 0, 1);
        txn(0, 2'd2, 0, 32'h10000004, 0, 32'hDEADBEEF, 1, 0, 0);
        txn(1, 2'd1, 0, 32'h10000006, 32'h0000BEEF, 0, 0, 0, 0);
        txn(1, 2'd0, 0, 32'h10000001, 32'h12345678, 0, 0, 1, 0);
        txn(1, 2'd2, 0, 32'h10000FFC, 32'hA5A55A5A, 0, 0, 0, 0);
        txn(0, 2'd2, 0, 32'h10000002, 0, 32'hFFFFFFFF, 0, 0, 0);
        txn(0, 2'd0, 0, 32'h20000000, 0, 32'hFFFFFFFF, 0, 0, 1);
        txn(1, 2'd3, 0, 32'h10000000, 32'h1, 0, 0, 0, 0);
        txn(0, 2'd1, 0, 32'h10000001, 0, 32'hFFFFFFFF, 0, 0, 0);
        txn(0, 2'd2, 0, 32'h10000010, 0, 32'hCAFEF00D, 3, 2, 4);

        // Reset while the load waits for its acknowledge.
        @(negedge clk);
        drive_req(0, 2'd2, 0, 32'h10000008, 0);
        @(negedge clk);
        req_valid = 1'b0;
        #1 chk("pre_rst_rd_en", mem_rd_en, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", req_ready, 1);
        chk("mid_rst_valid", rsp_valid, 0);
        chk("mid_rst_err", rsp_err, 0);
        chk("mid_rst_strobe", {mem_wr_en, mem_rd_en}, 0);
        chk("mid_rst_be", mem_be, 0);
        chk("mid_rst_addr", mem_addr, 0);
        chk("mid_rst_wd", mem_wr_data, 0);
        chk("mid_rst_rdata", rsp_rdata, 0);
        @(negedge clk);
        rst_n   = 1'b1;
        mem_ack = 1'b1;
        #1 chk("late_ack_valid", rsp_valid, 0);
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        chk("late_ack_idle", req_ready, 1);
        chk("late_ack_novalid", rsp_valid, 0);
        txn(0, 2'd0, 1, 32'h10000009, 0, 32'h0000C300, 0, 0, 0);

        // Acknowledge never arrives.
        @(negedge clk);
        drive_req(0, 2'd2, 0, 32'h1000000C, 0);
        @(negedge clk);
        req_valid = 1'b0;
        n    = 0;
        seen = 1'b0;
        for (int i = 1; i <= 40 && !seen; i++) begin
            #1;
            if (rsp_valid) begin
                seen = 1'b1;
                n    = i;
            end else begin
                @(negedge clk);
            end
        end
`ifdef DMEM_TIMEOUT_EN
        chk("to_cycle", n, TO + 1);
        chk("to_err", rsp_err, 1);
        chk("to_rdata", rsp_rdata, 0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        #1 chk("to_idle", req_ready, 1);
`else
        chk("no_to_valid", seen, 0);
        chk("no_to_busy", req_ready, 0);
        chk("no_to_cycle", n, 0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
`endif
        txn(0, 2'd1, 0, 32'h10000006, 0, 32'h7FFF0000, 0, 0, 0);

        chk("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
